// File: rtl/xor_parity_serializer.sv
// Parallel-to-serial transmit stage with an appended parity bit.
// Words arrive over a valid/ready handshake and leave LSB-first, one bit per
// output beat, followed by one parity bit (running XOR of the data bits,
// optionally inverted for odd parity). A word may be taken in the same cycle
// as the parity beat, so frames can follow each other with no idle gap.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no frame held; ready for a word, nothing presented downstream
// S_SHIFT | presenting data bit shreg_q[0]; cnt_q indexes the current bit
// S_PARITY| presenting the parity bit; a new word may load on its beat
module xor_parity_serializer #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int                 CNT_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(WIDTH - 1);
    localparam logic                ODD_BIT  = (ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   shreg_q,     shreg_d;
    logic [CNT_BITS-1:0] cnt_q,      cnt_d;
    logic               acc_q,       acc_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               out_bit_q,   out_bit_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q,  out_last_d;

    logic               accept;

    // Input side is open when idle, or when the parity bit is leaving this cycle.
    always_comb begin
        in_ready = (state_q == S_IDLE) || ((state_q == S_PARITY) && out_ready);
        accept   = in_valid && in_ready;
    end

    // Next-state and next-output computation; every register holds by default,
    // which is what gives stall-without-change when out_ready is low.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        frame_cnt_d = frame_cnt_q;
        out_bit_d   = out_bit_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_SHIFT;
                    shreg_d     = in_data;
                    cnt_d       = '0;
                    acc_d       = 1'b0;
                    out_bit_d   = in_data[0];
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                end
            end

            S_SHIFT: begin
                if (out_ready) begin
                    acc_d   = acc_q ^ shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    if (cnt_q == LAST_IDX) begin
                        // Last data bit leaves: parity is the updated accumulator.
                        state_d    = S_PARITY;
                        cnt_d      = '0;
                        out_bit_d  = acc_q ^ shreg_q[0] ^ ODD_BIT;
                        out_last_d = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + CNT_BITS'(1);
                        out_bit_d = shreg_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (out_ready) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    if (in_valid) begin
                        // Zero-bubble reload straight into the next frame.
                        state_d     = S_SHIFT;
                        shreg_d     = in_data;
                        cnt_d       = '0;
                        acc_d       = 1'b0;
                        out_bit_d   = in_data[0];
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                    end else begin
                        state_d     = S_IDLE;
                        out_bit_d   = 1'b0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d     = S_IDLE;
                out_bit_d   = 1'b0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            acc_q       <= 1'b0;
            frame_cnt_q <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            frame_cnt_q <= frame_cnt_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Outputs come straight from registers; in_data never reaches out_bit combinationally.
    always_comb begin
        out_bit   = out_bit_q;
        out_valid = out_valid_q;
        out_last  = out_last_q;
        frame_cnt = frame_cnt_q;
    end

endmodule

// File: tb/tb_xor_parity_serializer.sv
// Bench for xor_parity_serializer: an even- and an odd-parity instance share
// all inputs; a frame-level model (queue of expected bits) checks both.
module tb_xor_parity_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready_e, out_bit_e, out_valid_e, out_last_e;
    logic [7:0] frame_cnt_e;
    logic       in_ready_o, out_bit_o, out_valid_o, out_last_o;
    logic [7:0] frame_cnt_o;

    xor_parity_serializer #(.WIDTH(8), .ODD(0), .CNT_W(8)) u_even (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_e), .out_bit(out_bit_e), .out_valid(out_valid_e),
        .out_last(out_last_e), .out_ready(out_ready), .frame_cnt(frame_cnt_e));

    xor_parity_serializer #(.WIDTH(8), .ODD(1), .CNT_W(8)) u_odd (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_o), .out_bit(out_bit_o), .out_valid(out_valid_o),
        .out_last(out_last_o), .out_ready(out_ready), .frame_cnt(frame_cnt_o));

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    exp_t       exp_q[$];
    logic       par_e_hist[$];
    logic       par_o_hist[$];
    logic [7:0] model_frames = 8'd0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         beats    = 0;
    int         lasts    = 0;
    int         last_acc_cyc = 0;
    int         prev_acc_cyc = 0;
    int         ready_mode = 0;
    int         pidx = 0;
    logic       stall_prev = 1'b0, prev_bit = 1'b0, prev_last = 1'b0, acc_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // out_ready driver: always high, random, or the 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       out_ready = ($urandom_range(0, 1) == 1);
            2: begin
                out_ready = (pidx == 0) || (pidx == 3);
                pidx      = (pidx + 1) % 4;
            end
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor/model: sampled mid-cycle, ahead of the edge where beats/accepts land.
    always @(negedge clk) begin
        exp_t h;
        logic accept;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            model_frames = 8'd0;
            stall_prev   = 1'b0;
            acc_prev     = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", out_valid_e, 1);
                chk("stall_bit", out_bit_e, prev_bit);
                chk("stall_last", out_last_e, prev_last);
            end
            if (acc_prev) chk("latency_valid", out_valid_e, 1);
            chk("frame_cnt", frame_cnt_e, model_frames);
            chk("frame_cnt_odd", frame_cnt_o, model_frames);
            if (exp_q.size() == 0) begin
                chk("idle_valid", out_valid_e, 0);
                chk("idle_ready", in_ready_e, 1);
                chk("idle_last", out_last_e, 0);
                chk("odd_idle_valid", out_valid_o, 0);
            end else begin
                chk("busy_valid", out_valid_e, 1);
                chk("busy_last", out_last_e, exp_q[0].last);
                chk("busy_ready", in_ready_e, exp_q[0].last ? out_ready : 1'b0);
                chk("odd_busy_valid", out_valid_o, 1);
                chk("odd_busy_last", out_last_o, exp_q[0].last);
            end
            accept = in_valid && in_ready_e;
            if (out_valid_e && out_ready && exp_q.size() != 0) begin
                h = exp_q.pop_front();
                chk("bit", out_bit_e, h.b);
                chk("bit_odd", out_bit_o, h.b ^ h.last);
                beats++;
                if (h.last) begin
                    model_frames = model_frames + 8'd1;
                    lasts++;
                    par_e_hist.push_back(out_bit_e);
                    par_o_hist.push_back(out_bit_o);
                end
            end
            if (accept) begin
                for (int i = 0; i < 8; i++) exp_q.push_back('{b: in_data[i], last: 1'b0});
                exp_q.push_back('{b: ^in_data, last: 1'b1});
                prev_acc_cyc = last_acc_cyc;
                last_acc_cyc = cyc;
            end
            stall_prev = out_valid_e && !out_ready;
            prev_bit   = out_bit_e;
            prev_last  = out_last_e;
            acc_prev   = accept;
        end
    end

    task automatic send(input logic [7:0] w);
        logic ok;
        ok       = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready_e) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accepted", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic done;
        done     = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid_e) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", done, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int b0;
        int l0;
        logic got3;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valid", out_valid_e, 0);
        chk("reset_bit", out_bit_e, 0);
        chk("reset_fcnt", frame_cnt_e, 0);
        @(posedge clk);
        #1;

        // 1: A5, full throughput
        send(8'hA5);
        drain();
        chk("t1_par", par_e_hist[$], 0);
        chk("t1_par_odd", par_o_hist[$], 1);
        chk("t1_fcnt", frame_cnt_e, 1);

        // 2: 07, even vs odd parity
        send(8'h07);
        drain();
        chk("t2_par_even", par_e_hist[$], 1);
        chk("t2_par_odd", par_o_hist[$], 0);

        // 3: C3 with 1,0,0,1 backpressure
        ready_mode = 2;
        send(8'hC3);
        drain();
        chk("t3_par", par_e_hist[$], 0);
        ready_mode = 0;
        @(posedge clk);
        #1;

        // 4: back-to-back FF then 01
        send(8'hFF);
        send(8'h01);
        chk("t4_gap", last_acc_cyc - prev_acc_cyc, 9);
        drain();
        chk("t4_par_ff", par_e_hist[par_e_hist.size()-2], 0);
        chk("t4_par_01", par_e_hist[$], 1);

        // 5: reset mid-frame after 3 bits of 5A, then 80
        send(8'h5A);
        b0   = beats;
        got3 = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (beats - b0 >= 3) begin
                got3 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t5_three_bits", got3, 1);
        do_reset();
        @(negedge clk);
        chk("t5_valid", out_valid_e, 0);
        chk("t5_fcnt", frame_cnt_e, 0);
        chk("t5_ready", in_ready_e, 1);
        @(posedge clk);
        #1;
        send(8'h80);
        drain();
        chk("t5_par", par_e_hist[$], 1);
        chk("t5_fcnt_after", frame_cnt_e, 1);

        // 6: 256 random frames with random backpressure and gaps -> wrap
        do_reset();
        ready_mode = 1;
        l0 = lasts;
        for (int f = 0; f < 256; f++) begin
            send(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        ready_mode = 0;
        chk("t6_last_pulses", lasts - l0, 256);
        chk("t6_fcnt_wrap", frame_cnt_e, 0);
        chk("t6_fcnt_wrap_odd", frame_cnt_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
